// File: rtl/tt_check_pkg.sv
// rtl/tt_check_pkg.sv - shared FSM encoding and defaults for the truth table checker
package tt_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VEC = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SAMPLE   = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Default settle time between vector acceptance and response sampling.
  localparam int unsigned SETTLE_CYC_DEF = 2;

  // Settle counter width; covers the legal settle range 1..15.
  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter that flags the last settle cycle
module settle_timer
  import tt_check_pkg::*;
#(
  parameter int unsigned W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while counting, never below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Expire on the final counting cycle so the caller leaves settle after exactly load_val cycles.
  always_comb begin
    expire = count && (cnt_q == W'(1));
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - applies/accepts vectors and checks a 1-bit DUT against a truth table
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned NIN        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2**NIN-1:0]   exp_table,
  input  logic                vec_valid,
  input  logic [NIN-1:0]      vec,
  output logic                vec_ready,
  input  logic                dut_out,
  input  logic                stop,
  output logic                done,
  output logic                pass,
  output logic [NIN:0]        err_count,
  output logic [NIN-1:0]      first_fail_vec,
  output logic                first_fail_valid,
  output logic [2**NIN-1:0]   seen_mask
);

  localparam int unsigned DEPTH = 2**NIN;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic [NIN-1:0]   vec_q, vec_d;
  logic [NIN:0]     err_q, err_d;
  logic [NIN-1:0]   ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic [DEPTH-1:0] seen_q, seen_d;
  logic             stop_pend_q, stop_pend_d;

  logic             tmr_load;
  logic             tmr_count;
  logic             tmr_expire;
  logic [DEPTH-1:0] seen_upd;

  settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  // Next-state and result bookkeeping; a stop seen while settling is remembered until the sample.
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    vec_d       = vec_q;
    err_d       = err_q;
    ffv_d       = ffv_q;
    ffvalid_d   = ffvalid_q;
    seen_d      = seen_q;
    stop_pend_d = stop_pend_q;
    tmr_load    = 1'b0;
    tmr_count   = 1'b0;
    seen_upd    = seen_q;
    vec_ready   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT_VEC;
          table_d     = exp_table;
          err_d       = '0;
          seen_d      = '0;
          ffvalid_d   = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      ST_WAIT_VEC: begin
        vec_ready = 1'b1;
        if (stop) begin
          state_d = ST_DONE;
        end else if (vec_valid) begin
          vec_d       = vec;
          tmr_load    = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_count = 1'b1;
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        seen_upd        = seen_q;
        seen_upd[vec_q] = 1'b1;
        seen_d          = seen_upd;
        if (dut_out != table_q[vec_q]) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if ((&seen_upd) || stop || stop_pend_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_VEC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode from state so reset clears them without waiting for an edge.
  always_comb begin
    done             = (state_q == ST_DONE);
    pass             = done && (err_q == '0) && (&seen_q);
    err_count        = err_q;
    first_fail_vec   = ffv_q;
    first_fail_valid = ffvalid_q;
    seen_mask        = seen_q;
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      table_q     <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      ffv_q       <= '0;
      ffvalid_q   <= 1'b0;
      seen_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      ffv_q       <= ffv_d;
      ffvalid_q   <= ffvalid_d;
      seen_q      <= seen_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized self-checking bench with a transaction-level model
module tb_truth_table_checker;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] exp_table;
  logic        vec_valid;
  logic [3:0]  vec;
  logic        vec_ready;
  logic        dut_out;
  logic        stop;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_vec;
  logic        first_fail_valid;
  logic [15:0] seen_mask;

  int checks = 0;
  int errors = 0;

  // Model of the run: busy countdown after each acceptance, results applied on the last busy cycle.
  bit        m_run, m_done, m_ffvalid, m_stop_pend, m_acc;
  bit [15:0] m_table, m_seen;
  bit [3:0]  m_pend, m_ffv;
  int        m_err, m_wait;
  int        dmode;

  truth_table_checker #(
    .SETTLE_CYC (S),
    .NIN        (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .exp_table        (exp_table),
    .vec_valid        (vec_valid),
    .vec              (vec),
    .vec_ready        (vec_ready),
    .dut_out          (dut_out),
    .stop             (stop),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .seen_mask        (seen_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ffvalid = 0; m_stop_pend = 0; m_acc = 0;
    m_table = 0; m_seen = 0; m_pend = 0; m_ffv = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_step();
    m_acc = 0;
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_table = exp_table; m_err = 0;
        m_seen = 0; m_ffvalid = 0; m_wait = 0; m_stop_pend = 0;
      end
    end else if (m_wait == 0) begin
      if (stop) begin
        m_run = 0; m_done = 1;
      end else if (vec_valid) begin
        m_pend = vec; m_wait = S + 1; m_stop_pend = 0; m_acc = 1;
      end
    end else if (m_wait > 1) begin
      if (stop) m_stop_pend = 1;
      m_wait--;
    end else begin
      if (dut_out != m_table[m_pend]) begin
        if (m_err < 31) m_err++;
        if (!m_ffvalid) begin m_ffv = m_pend; m_ffvalid = 1; end
      end
      m_seen[m_pend] = 1'b1;
      m_wait = 0;
      if (m_seen == 16'hFFFF || stop || m_stop_pend) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  function automatic logic dut_fn();
    case (dmode)
      0: dut_fn = |m_pend;
      1: dut_fn = 1'b1;
      2: dut_fn = ~m_table[m_pend];
      3: dut_fn = m_table[m_pend];
      default: dut_fn = 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic compare_all();
    chk("vec_ready", vec_ready, (m_run && m_wait == 0));
    chk("done", done, m_done);
    chk("pass", pass, (m_done && m_err == 0 && m_seen == 16'hFFFF));
    chk("err_count", err_count, m_err);
    chk("first_fail_valid", first_fail_valid, m_ffvalid);
    chk("first_fail_vec", first_fail_vec, m_ffv);
    chk("seen_mask", seen_mask, m_seen);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    dut_out = dut_fn();
  endtask

  task automatic do_start(input logic [15:0] tbl);
    start = 1'b1;
    exp_table = tbl;
    cycle();
    start = 1'b0;
    exp_table = 16'($urandom);
  endtask

  task automatic send_vec(input logic [3:0] v);
    int n;
    n = 0;
    vec = v;
    vec_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 50);
    chk("accept_bound", (n < 50), 1);
    vec_valid = 1'b0;
    vec = 4'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!m_done && n < 100) begin
      cycle();
      n++;
    end
    chk("done_bound", (n < 100), 1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(m_run && m_wait == 0) && n < 100) begin
      cycle();
      n++;
    end
    chk("ready_bound", (n < 100), 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; exp_table = 16'h0; vec_valid = 1'b0;
    vec = 4'h0; dut_out = 1'b0; stop = 1'b0; dmode = 0;
    model_reset();
    #1;
    chk("reset_ready", vec_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_seen", seen_mask, 0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // OR-gate DUT, all vectors in order.
    dmode = 0;
    do_start(16'hFFFE);
    for (int i = 0; i < 16; i++) send_vec(4'(i));
    wait_done();
    chk("or_done", done, 1);
    chk("or_pass", pass, 1);
    chk("or_err", err_count, 0);
    chk("or_seen", seen_mask, 16'hFFFF);

    // DUT stuck at 1: only vector 0 mismatches.
    dmode = 1;
    do_start(16'hFFFE);
    for (int i = 0; i < 16; i++) send_vec(4'(i));
    wait_done();
    chk("stuck_err", err_count, 1);
    chk("stuck_ffv", first_fail_vec, 0);
    chk("stuck_ffvalid", first_fail_valid, 1);
    chk("stuck_pass", pass, 0);

    // Half the vectors then stop.
    dmode = 0;
    do_start(16'hFFFE);
    for (int i = 0; i < 8; i++) send_vec(4'(i));
    wait_ready();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_done", done, 1);
    chk("stop_seen", seen_mask, 16'h00FF);
    chk("stop_pass", pass, 0);

    // vec_valid held high: one acceptance per S+2 cycles.
    do_start(16'hFFFE);
    vec_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 * (S + 2); i++) begin
      vec = 4'($urandom);
      if (vec_ready && vec_valid) cnt++;
      cycle();
    end
    vec_valid = 1'b0;
    chk("hold_valid_accepts", cnt, 10);

    // Reset during settle of vector 5, then a clean run.
    do_start(16'hFFFE);
    for (int i = 0; i < 6; i++) send_vec(4'(i));
    rst = 1'b1;
    #1;
    chk("rst_ready", vec_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffvalid", first_fail_valid, 0);
    chk("rst_ffv", first_fail_vec, 0);
    chk("rst_seen", seen_mask, 0);
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
    do_start(16'hFFFE);
    for (int i = 0; i < 16; i++) send_vec(4'(i));
    wait_done();
    chk("after_rst_pass", pass, 1);

    // Inverted DUT, 40 vectors with repeats: error count saturates.
    dmode = 2;
    do_start(16'($urandom));
    for (int i = 0; i < 40; i++) send_vec((i < 39) ? 4'(i % 15) : 4'd15);
    wait_done();
    chk("sat_err", err_count, 5'h1F);
    chk("sat_ffv", first_fail_vec, 0);
    chk("sat_done", done, 1);
    chk("sat_pass", pass, 0);

    // Fully random traffic, including stray starts, stops and resets.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      if (start) dmode = $urandom_range(0, 4);
      exp_table = 16'($urandom);
      vec_valid = 1'($urandom_range(0, 1));
      vec = 4'($urandom);
      stop = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; vec_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 2, SHALL set the clock cycles between vector acceptance and DUT output sampling; legal range 1..15.
REQ-002 Parameter NIN, default 4, SHALL set the stimulus vector width; table depth is 2**NIN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; latches exp_table and begins a check run.
REQ-006 exp_table  input  2**NIN  expected DUT output, bit i for input vector i; sampled only on the start cycle.
REQ-007 vec_valid  input  1  stimulus source presents a vector.
REQ-008 vec  input  NIN  applied input vector (x,y,z,m order, MSB = x).
REQ-009 vec_ready  output  1  checker accepts a vector this cycle.
REQ-010 dut_out  input  1  single-bit response of the DUT under check.
REQ-011 stop  input  1  ends the run early.
REQ-012 done  output  1  run finished; held until next start.
REQ-013 pass  output  1  valid when done; 1 iff err_count==0 and all vectors covered.
REQ-014 err_count  output  NIN+1  number of mismatches, saturating at all-ones.
REQ-015 first_fail_vec  output  NIN  first mismatching vector; first_fail_valid  output  1  flags it.
REQ-016 seen_mask  output  2**NIN  bit i set once vector i has been checked.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: vec_ready=0; start -> WAIT_VEC, latching exp_table and clearing err_count, seen_mask, first_fail_valid, done.
REQ-019 WAIT_VEC: vec_ready=1; a vector is accepted only when vec_valid && vec_ready; on acceptance vec is registered and FSM goes to SETTLE.
REQ-020 SETTLE: vec_ready=0; counts SETTLE_CYC cycles, then -> SAMPLE; vec_valid is ignored.
REQ-021 SAMPLE: compares dut_out to latched table bit [vec]; on mismatch err_count increments (saturating), and if first_fail_valid==0 then first_fail_vec=vec and first_fail_valid=1; seen_mask[vec] is set regardless.
REQ-022 After SAMPLE: -> DONE if seen_mask (including this update) is all ones or stop is high; else -> WAIT_VEC.
REQ-023 A repeated vector SHALL be rechecked and counted again on mismatch; coverage is unaffected.
REQ-024 stop in WAIT_VEC -> DONE next cycle; stop in SETTLE is deferred until that vector's SAMPLE completes.
REQ-025 DONE: done=1, pass per REQ-013; start -> re-arm per REQ-018; otherwise holds.
REQ-026 start outside IDLE and DONE SHALL be ignored.
REQ-027 Latency acceptance-to-result: SETTLE_CYC+1 cycles; minimum vector period SETTLE_CYC+2 cycles.
REQ-028 pass SHALL be 0 whenever done is 0.

Reset
REQ-029 rst SHALL immediately force IDLE, vec_ready=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, seen_mask=0, settle counter=0, latched table=0.
REQ-030 rst mid-run SHALL discard the run; no partial result remains visible.

Structure
REQ-031 FSM state encoding and SETTLE_CYC default SHALL live in shared package tt_check_pkg.
REQ-032 The settle counter SHALL be a sub-module settle_timer (load, count, expire) instantiated once.

Verification
REQ-033 Table 16'hFFFE on OR-gate DUT, vectors 0..15 in order -> done, pass=1, err_count=0, seen_mask=16'hFFFF.
REQ-034 Same, DUT forced to 1 -> err_count=1, first_fail_vec=0, pass=0.
REQ-035 Only vectors 0..7 then stop -> done, seen_mask=16'h00FF, pass=0.
REQ-036 vec_valid held high during SETTLE -> exactly one acceptance per SETTLE_CYC+2 cycles.
REQ-037 rst asserted during SETTLE of vector 5 -> all outputs zero same cycle; new start run completes normally.
REQ-038 DUT inverted, 40 vectors incl. repeats -> err_count saturates at 5'h1F.
